// File: rtl/cond_check.sv
// ARM-style condition check for the execute stage.
// Evaluates Cond against NZCV, gates writes, holds the NZCV register.
module cond_check (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagWrite,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  output logic       CondEx,
  output logic [3:0] FlagsOut,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite
);

  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;
  logic       w_ge;
  logic       w_cond;
  logic       w_wr_nz;
  logic       w_wr_cv;
  logic [3:0] r_flags;

  assign w_n  = Flags[3];
  assign w_z  = Flags[2];
  assign w_c  = Flags[1];
  assign w_v  = Flags[0];
  assign w_ge = (w_n == w_v);

  always_comb begin
    w_cond = 1'b0;
    unique case (Cond)
      4'b0000: w_cond = w_z;
      4'b0001: w_cond = ~w_z;
      4'b0010: w_cond = w_c;
      4'b0011: w_cond = ~w_c;
      4'b0100: w_cond = w_n;
      4'b0101: w_cond = ~w_n;
      4'b0110: w_cond = w_v;
      4'b0111: w_cond = ~w_v;
      4'b1000: w_cond = w_c & ~w_z;
      4'b1001: w_cond = ~w_c | w_z;
      4'b1010: w_cond = w_ge;
      4'b1011: w_cond = ~w_ge;
      4'b1100: w_cond = ~w_z & w_ge;
      4'b1101: w_cond = w_z | ~w_ge;
      4'b1110: w_cond = 1'b1;
      4'b1111: w_cond = 1'b0;
      default: w_cond = 1'b0;
    endcase
  end

  assign CondEx   = w_cond;
  assign PCSrc    = PCS  & w_cond;
  assign RegWrite = RegW & w_cond;
  assign MemWrite = MemW & w_cond;

  assign w_wr_nz = FlagWrite[1] & w_cond;
  assign w_wr_cv = FlagWrite[0] & w_cond;

  // NZ and CV halves update independently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else begin
      if (w_wr_nz) r_flags[3:2] <= ALUFlags[3:2];
      if (w_wr_cv) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

  assign FlagsOut = r_flags;

endmodule

// File: tb/tb_cond_check.sv
// Self-checking bench for cond_check.
// Directed plan cases, then random traffic against a reference model.
module tb_cond_check;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] Flags;
  logic [3:0] ALUFlags;
  logic [1:0] FlagWrite;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       CondEx;
  logic [3:0] FlagsOut;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;

  int n_chk;
  int n_err;

  logic [3:0] m_flags;

  cond_check dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .Flags    (Flags),
    .ALUFlags (ALUFlags),
    .FlagWrite(FlagWrite),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .CondEx   (CondEx),
    .FlagsOut (FlagsOut),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [3:0] got,
    input logic [3:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", tag, got, exp);
    end
  endtask

  // Even codes name a base test, odd codes its negation; 14/15 fixed.
  function automatic logic ref_cond(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic tcond(
    input string      tag,
    input logic [3:0] f,
    input logic [3:0] c,
    input logic       e
  );
    Flags = f;
    Cond  = c;
    #1;
    chk(tag, {3'b0, CondEx}, {3'b0, e});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] zero_tbl;

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    Cond = 4'd14;
    Flags = 4'd0;
    ALUFlags = 4'd0;
    FlagWrite = 2'b00;
    PCS = 1'b0;
    RegW = 1'b0;
    MemW = 1'b0;
    #2;
    chk("reset_state", FlagsOut, 4'b0000);

    // LSB is Cond 0000
    zero_tbl = 16'b0101_0110_1010_1010;
    for (int i = 0; i < 16; i++)
      tcond($sformatf("f0_c%0d", i), 4'b0000,
            i[3:0], zero_tbl[i]);

    tcond("z_eq", 4'b0100, 4'b0000, 1'b1);
    tcond("z_ne", 4'b0100, 4'b0001, 1'b0);
    tcond("z_hi", 4'b0100, 4'b1000, 1'b0);
    tcond("z_ls", 4'b0100, 4'b1001, 1'b1);
    tcond("z_gt", 4'b0100, 4'b1100, 1'b0);
    tcond("z_le", 4'b0100, 4'b1101, 1'b1);
    tcond("nv_ge", 4'b1001, 4'b1010, 1'b1);
    tcond("nv_lt", 4'b1001, 4'b1011, 1'b0);
    tcond("nv_gt", 4'b1001, 4'b1100, 1'b1);
    tcond("n_ge", 4'b1000, 4'b1010, 1'b0);
    tcond("n_lt", 4'b1000, 4'b1011, 1'b1);
    tcond("n_le", 4'b1000, 4'b1101, 1'b1);
    tcond("n_mi", 4'b1000, 4'b0100, 1'b1);
    tcond("n_pl", 4'b1000, 4'b0101, 1'b0);
    tcond("c_cs", 4'b0010, 4'b0010, 1'b1);
    tcond("c_hi", 4'b0010, 4'b1000, 1'b1);
    tcond("c_ls", 4'b0010, 4'b1001, 1'b0);

    // Load the register, then hit it with a mid-cycle reset
    @(negedge clk);
    reset = 1'b0;
    Cond = 4'b1110;
    FlagWrite = 2'b11;
    ALUFlags = 4'b0110;
    tick();
    chk("pre_load", FlagsOut, 4'b0110);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", FlagsOut, 4'b0000);
    #1;
    reset = 1'b0;
    ALUFlags = 4'b1011;
    tick();
    chk("load_1011", FlagsOut, 4'b1011);

    FlagWrite = 2'b10;
    ALUFlags = 4'b0100;
    tick();
    chk("nz_only", FlagsOut, 4'b0111);

    Cond = 4'b0000;
    Flags = 4'b0000;
    FlagWrite = 2'b11;
    ALUFlags = 4'b1000;
    tick();
    chk("cond_fail_hold", FlagsOut, 4'b0111);

    Cond = 4'b1110;
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
    #1;
    chk("gate_on", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0111);
    Cond = 4'b1111;
    #1;
    chk("gate_off", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);

    // Random traffic
    m_flags = FlagsOut === 4'b0111 ? 4'b0111 : 4'b0111;
    for (int k = 0; k < 400; k++) begin
      logic e;
      @(negedge clk);
      Cond = 4'($urandom);
      Flags = 4'($urandom);
      ALUFlags = 4'($urandom);
      FlagWrite = 2'($urandom);
      PCS = 1'($urandom);
      RegW = 1'($urandom);
      MemW = 1'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b1;
        m_flags = 4'b0000;
        #1;
        chk("rnd_reset", FlagsOut, m_flags);
        reset = 1'b0;
      end
      #1;
      e = ref_cond(Cond, Flags);
      chk("rnd_condex", {3'b0, CondEx}, {3'b0, e});
      chk("rnd_gates", {1'b0, PCSrc, RegWrite, MemWrite},
          {1'b0, PCS & e, RegW & e, MemW & e});
      if (e && FlagWrite[1]) m_flags[3:2] = ALUFlags[3:2];
      if (e && FlagWrite[0]) m_flags[1:0] = ALUFlags[1:0];
      tick();
      chk("rnd_flags", FlagsOut, m_flags);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
